ex_forward_hazard_ctrl: RTL and testbench
=========================================

// Module: ex_forward_hazard_ctrl
// PURPOSE
//   Sequencing and forwarding controller for the EX stage of the 5-stage pipeline.
//   Tracks the register destinations of the instructions in EX, MEM and WB, and drives the EX operand-mux selects.
//   Detects load-use hazards and multi-cycle EX operations, and produces the front-end stall and bubble controls.
//   Sits between decode (ID) and the EX datapath; it holds no operand data, only register tags.
// PARAMETERS
//   REG_BITS    5  register index width (32 GPRs, r0 hardwired zero)
//   MC_LATENCY  4  total EX cycles of a multi-cycle op (1..16; 1 = no hold)
// PORTS
//   clock          in   1         rising-edge clock
//   reset          in   1         synchronous, active-high
//   id_valid       in   1         ID holds a real instruction
//   id_rs          in   REG_BITS  first source register
//   id_rt          in   REG_BITS  second source register
//   id_uses_rt     in   1         rt is a true source (not only a destination)
//   id_use_imm     in   1         second ALU operand is the immediate
//   id_dest        in   REG_BITS  destination register
//   id_regwrite    in   1         instruction writes id_dest
//   id_memread     in   1         instruction is a load
//   id_multicycle  in   1         EX op needs MC_LATENCY cycles
//   ex_flush       in   1         kill the ID instruction (taken branch)
//   controle1P     out  1         first-operand mux select, high bit
//   controle2P     out  1         first-operand mux select, low bit
//   controle1S     out  1         second-operand mux select, high bit
//   controle2S     out  1         second-operand mux select, low bit
//   controleDoMUx2 out  1         1 = immediate as ALU B operand
//   pc_write       out  1         0 = hold PC
//   ifid_write     out  1         0 = hold IF/ID register
//   ex_hold        out  1         1 = EX/ID-EX register must not advance
//   mem_bubble     out  1         1 = EX/MEM register receives a bubble
// BEHAVIOUR
//   - Internal tag stages EX/MEM/WB each hold {valid, dest, regwrite}; EX additionally holds {rs, rt, uses_rt, use_imm, memread, multicycle}.
//   - Select encoding {ctl1,ctl2}: 00 = register file, 01 = Memoria (EX/MEM result), 10 = registrado (MEM/WB result); 11 is never driven.
//   - Forwarding is combinational from the tag registers (valid in the same cycle the instruction occupies EX).
//   - Operand A: if MEM.valid && MEM.regwrite && MEM.dest != 0 && MEM.dest == EX.rs, select 01.
//     Else if the same condition holds for WB, select 10. Else select 00. MEM has priority over WB.
//   - Operand B: same rule using EX.rt, gated by EX.uses_rt. controleDoMUx2 = EX.valid && EX.use_imm.
//   - Load-use stall (comb.): EX.valid && EX.memread && EX.dest != 0 && id_valid && (EX.dest == id_rs || (id_uses_rt && EX.dest == id_rt)).
//     On this stall, pc_write = ifid_write = 0 and EX receives a bubble on the next edge. The stall lasts exactly 1 cycle.
//   - FSM states RUN and MC_BUSY, with counter cnt of width $clog2(MC_LATENCY)+1.
//     - RUN -> MC_BUSY when an instruction with multicycle = 1 enters EX and MC_LATENCY > 1; cnt is loaded with MC_LATENCY-1.
//     - In MC_BUSY, cnt decrements each cycle. MC_BUSY -> RUN on the edge where cnt goes 1 -> 0.
//     - While in MC_BUSY: ex_hold = 1, mem_bubble = 1, pc_write = ifid_write = 0. EX keeps its tags and WB <- MEM.
//   - Advancing edge (RUN, not stalled): WB <- MEM, MEM <- EX, EX <- ID tags; EX.valid = id_valid && !ex_flush.
//   - Priority: reset > MC_BUSY hold > load-use stall > flush.
//     ex_flush is ignored while holding; its source keeps it asserted until an advancing edge.
//   - A load-use stall coinciding with MC_BUSY is absorbed by the hold and re-evaluated after it.
//   - Dest r0 never forwards and never stalls.
//   - Reset: all valid bits 0, state RUN, cnt 0.
//     Outputs: all selects 0, controleDoMUx2 0, pc_write 1, ifid_write 1, ex_hold 0, mem_bubble 0.
//     Reset mid-MC_BUSY aborts the hold on the next edge.
// TESTING
//   1. add r3 in EX->MEM, next instr rs=3 in EX -> {controle1P,controle2P} = 01; one stage later with WB dest 3 only -> 10.
//   2. MEM and WB both dest r5, EX rt=5, uses_rt=1 -> {controle1S,controle2S} = 01 (MEM priority); uses_rt=0 -> 00.
//   3. lw r4 in EX, ID rs=4 -> exactly 1 cycle pc_write=0, ifid_write=0; EX bubble; then forward 10 from WB.
//   4. multicycle op enters EX, MC_LATENCY=4 -> ex_hold=1 for 3 cycles, 3 MEM bubbles, then RUN; flush during hold ignored.
//   5. dest r0 with regwrite=1 in MEM/WB, EX rs=rt=0 -> all selects 00; lw r0 in EX -> no stall.
//   6. reset asserted in 2nd MC_BUSY cycle -> next edge: state RUN, ex_hold=0, pc_write=1, all selects 00.

Source files
------------

// File: rtl/ex_forward_hazard_ctrl_if.sv
// ID-stage tags in, EX operand selects and front-end stall controls out; no latency of its own.
// Backpressure: pc_write/ifid_write/ex_hold tell ID and the datapath when to hold.
interface ex_forward_hazard_ctrl_if #(
    parameter int REG_BITS = 5
) ();
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_uses_rt;
    logic                id_use_imm;
    logic [REG_BITS-1:0] id_dest;
    logic                id_regwrite;
    logic                id_memread;
    logic                id_multicycle;
    logic                ex_flush;

    logic controle1P;
    logic controle2P;
    logic controle1S;
    logic controle2S;
    logic controleDoMUx2;
    logic pc_write;
    logic ifid_write;
    logic ex_hold;
    logic mem_bubble;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_use_imm, id_dest,
               id_regwrite, id_memread, id_multicycle, ex_flush,
        input  controle1P, controle2P, controle1S, controle2S, controleDoMUx2,
               pc_write, ifid_write, ex_hold, mem_bubble
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_use_imm, id_dest,
               id_regwrite, id_memread, id_multicycle, ex_flush,
        output controle1P, controle2P, controle1S, controle2S, controleDoMUx2,
               pc_write, ifid_write, ex_hold, mem_bubble
    );
endinterface

// File: rtl/ex_forward_hazard_ctrl.sv
// EX-stage forwarding/hazard controller: selects are combinational from EX/MEM/WB tag registers.
// Backpressure: 1-cycle PC/IF-ID hold on load-use, MC_LATENCY-1 cycle EX hold for multi-cycle ops.
module ex_forward_hazard_ctrl #(
    parameter int REG_BITS   = 5,
    parameter int MC_LATENCY = 4
) (
    input logic                    clock,
    input logic                    reset,
    ex_forward_hazard_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MC_LATENCY) + 1;

    typedef enum logic {RUN, MC_BUSY} state_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                uses_rt;
        logic                use_imm;
        logic                memread;
        logic                multicycle;
    } ex_tag_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
    } stage_tag_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ex_tag_t          ex_q, ex_d;
    stage_tag_t       mem_q, mem_d;
    stage_tag_t       wb_q, wb_d;

    logic    busy;
    logic    load_use;
    logic    stall;
    ex_tag_t id_tag;
    logic    mem_fwd_ok, wb_fwd_ok;
    logic [1:0] sel_a, sel_b;

    always_comb begin
        busy = (state_q == MC_BUSY);

        // r0 is never a real producer, so it neither stalls nor forwards
        load_use = ex_q.valid && ex_q.memread && (ex_q.dest != '0) && bus.id_valid &&
                   ((ex_q.dest == bus.id_rs) || (bus.id_uses_rt && (ex_q.dest == bus.id_rt)));
        stall    = !busy && load_use;

        id_tag.valid      = bus.id_valid && !bus.ex_flush;
        id_tag.dest       = bus.id_dest;
        id_tag.regwrite   = bus.id_regwrite;
        id_tag.rs         = bus.id_rs;
        id_tag.rt         = bus.id_rt;
        id_tag.uses_rt    = bus.id_uses_rt;
        id_tag.use_imm    = bus.id_use_imm;
        id_tag.memread    = bus.id_memread;
        id_tag.multicycle = bus.id_multicycle;

        mem_fwd_ok = mem_q.valid && mem_q.regwrite && (mem_q.dest != '0);
        wb_fwd_ok  = wb_q.valid && wb_q.regwrite && (wb_q.dest != '0);

        sel_a = 2'b00;
        if (mem_fwd_ok && (mem_q.dest == ex_q.rs)) begin
            sel_a = 2'b01;
        end else if (wb_fwd_ok && (wb_q.dest == ex_q.rs)) begin
            sel_a = 2'b10;
        end

        sel_b = 2'b00;
        if (ex_q.uses_rt) begin
            if (mem_fwd_ok && (mem_q.dest == ex_q.rt)) begin
                sel_b = 2'b01;
            end else if (wb_fwd_ok && (wb_q.dest == ex_q.rt)) begin
                sel_b = 2'b10;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;

        if (busy) begin
            // EX keeps its op; the MEM slot behind it drains as bubbles
            wb_d  = mem_q;
            mem_d = '0;
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q <= CNT_W'(1)) || !ex_q.multicycle) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (stall) begin
            wb_d  = mem_q;
            mem_d = '{valid: ex_q.valid, dest: ex_q.dest, regwrite: ex_q.regwrite};
            ex_d  = '0;
        end else begin
            wb_d  = mem_q;
            mem_d = '{valid: ex_q.valid, dest: ex_q.dest, regwrite: ex_q.regwrite};
            ex_d  = id_tag;
            if (id_tag.valid && id_tag.multicycle && (MC_LATENCY > 1)) begin
                state_d = MC_BUSY;
                cnt_d   = CNT_W'(MC_LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.controle1P     = sel_a[1];
    assign bus.controle2P     = sel_a[0];
    assign bus.controle1S     = sel_b[1];
    assign bus.controle2S     = sel_b[0];
    assign bus.controleDoMUx2 = ex_q.valid && ex_q.use_imm;
    assign bus.pc_write       = !(busy || stall);
    assign bus.ifid_write     = !(busy || stall);
    assign bus.ex_hold        = busy;
    assign bus.mem_bubble     = busy;

endmodule

// File: tb/tb_ex_forward_hazard_ctrl.sv
// Directed pipeline scenarios; expected control vectors queued per cycle and checked by a monitor.
module tb_ex_forward_hazard_ctrl;
    logic clock;
    logic reset;

    ex_forward_hazard_ctrl_if #(.REG_BITS(5)) bus ();

    ex_forward_hazard_ctrl #(.REG_BITS(5), .MC_LATENCY(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {selA[1:0], selB[1:0], mux2, pc_write, ifid_write, ex_hold, mem_bubble}
    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    localparam logic [8:0] NORMAL = 9'b000001100;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic imm, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic mc, input logic fl);
        bus.id_valid      = v;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_uses_rt    = urt;
        bus.id_use_imm    = imm;
        bus.id_dest       = dest;
        bus.id_regwrite   = rw;
        bus.id_memread    = mr;
        bus.id_multicycle = mc;
        bus.ex_flush      = fl;
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic [8:0] e);
        sb_t ent;
        ent.name = nm;
        ent.exp  = e;
        sb_q.push_back(ent);
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_t        ent;
            logic [8:0] act;
            ent = sb_q.pop_front();
            act = {bus.controle1P, bus.controle2P, bus.controle1S, bus.controle2S,
                   bus.controleDoMUx2, bus.pc_write, bus.ifid_write, bus.ex_hold, bus.mem_bubble};
            n_checks++;
            if (act !== ent.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", ent.name, act, ent.exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        nop();
        next_cycle();
        next_cycle();
        expect_out("reset_state", NORMAL);

        // c1: add r3 in ID
        next_cycle();
        reset = 1'b0;
        id_set(1, 5'd1, 5'd2, 1, 0, 5'd3, 1, 0, 0, 0);
        expect_out("t1_idle", NORMAL);
        // c2: add in EX; next instr reads r3
        next_cycle();
        id_set(1, 5'd3, 5'd0, 0, 0, 5'd6, 1, 0, 0, 0);
        expect_out("t1_ex_add", NORMAL);
        // c3: add in MEM, reader in EX -> 01
        next_cycle();
        id_set(1, 5'd3, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0);
        expect_out("t1_fwd_mem", 9'b010001100);
        // c4: add in WB, second reader in EX -> 10
        next_cycle();
        nop();
        expect_out("t1_fwd_wb", 9'b100001100);

        // c5..c7: two writers of r5, then reader of rt=r5
        next_cycle();
        id_set(1, 5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0);
        next_cycle();
        id_set(1, 5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0);
        next_cycle();
        id_set(1, 5'd9, 5'd5, 1, 0, 5'd8, 1, 0, 0, 0);
        // c8: MEM and WB both r5 -> B selects MEM
        next_cycle();
        id_set(1, 5'd9, 5'd5, 0, 1, 5'd0, 0, 0, 0, 0);
        expect_out("t2_mem_prio", 9'b000101100);
        // c9: rt=5 but uses_rt=0 with WB r5 -> 00, immediate selected
        next_cycle();
        id_set(1, 5'd1, 5'd4, 0, 1, 5'd4, 1, 1, 0, 0);
        expect_out("t2_no_uses_rt", 9'b000011100);

        // c10: lw r4 in EX, ID reads r4 -> stall
        next_cycle();
        id_set(1, 5'd4, 5'd2, 1, 0, 5'd10, 1, 0, 0, 0);
        expect_out("t3_stall", 9'b000010000);
        // c11: bubble in EX, ID held -> stall released
        next_cycle();
        expect_out("t3_after_stall", NORMAL);
        // c12: consumer in EX, lw in WB -> 10
        next_cycle();
        id_set(1, 5'd1, 5'd1, 0, 0, 5'd0, 1, 0, 0, 0);
        expect_out("t3_fwd_wb", 9'b100001100);

        // c13..c14: two r0 writers, then reader of r0 on both ports
        next_cycle();
        id_set(1, 5'd1, 5'd1, 0, 0, 5'd0, 1, 0, 0, 0);
        next_cycle();
        id_set(1, 5'd0, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0);
        // c15: r0 in MEM/WB never forwards
        next_cycle();
        id_set(1, 5'd2, 5'd0, 0, 1, 5'd0, 1, 1, 0, 0);
        expect_out("t5_r0_nofwd", NORMAL);
        // c16: lw r0 in EX, ID reads r0 -> no stall
        next_cycle();
        id_set(1, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
        expect_out("t5_lw_r0_nostall", 9'b000011100);

        // c17: multicycle op in ID
        next_cycle();
        id_set(1, 5'd1, 5'd2, 1, 0, 5'd11, 1, 0, 1, 0);
        expect_out("t4_pre", NORMAL);
        // c18..c20: hold, flush asserted during the hold
        next_cycle();
        id_set(1, 5'd11, 5'd0, 0, 0, 5'd12, 1, 0, 0, 1);
        expect_out("t4_hold1", 9'b000000011);
        next_cycle();
        expect_out("t4_hold2", 9'b000000011);
        next_cycle();
        expect_out("t4_hold3", 9'b000000011);
        // c21: back in RUN, op's last EX cycle
        next_cycle();
        bus.ex_flush = 1'b0;
        expect_out("t4_run", NORMAL);
        // c22: op survived the flush and forwards from MEM
        next_cycle();
        id_set(1, 5'd12, 5'd0, 0, 0, 5'd13, 1, 0, 1, 0);
        expect_out("t4_run_fwd", 9'b010001100);

        // c23: second multicycle op, first hold cycle
        next_cycle();
        nop();
        expect_out("t6_hold1", 9'b010000011);
        // c24: second hold cycle, reset asserted
        next_cycle();
        reset = 1'b1;
        expect_out("t6_hold2", 9'b100000011);
        // c25: reset aborted the hold
        next_cycle();
        reset = 1'b0;
        expect_out("t6_reset_abort", NORMAL);
        next_cycle();
        expect_out("t6_after", NORMAL);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge clock);
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
